// File: rtl/patch_histogram_engine.sv
// Scans a PATCH_SIZE x PATCH_SIZE gradient patch, bins every pixel into 8 orientation octants and streams
// one saturating histogram per subpatch. Define PATCH_HIST_MAGNITUDE_EN to accumulate |gx|+|gy| per pixel.
// With hist_ready_in held high, done_out rises PATCH_SIZE^2 + READ_LATENCY + NUM_SUB + 3 clocks after the
// edge that samples start_in (the out-of-bounds pulse comes 1 clock after that edge).
module patch_histogram_engine #(
    parameter int unsigned WIDTH        = 64,
    parameter int unsigned HEIGHT       = 64,
    parameter int unsigned BIT_DEPTH    = 8,
    parameter int unsigned PATCH_SIZE   = 8,
    parameter int unsigned SUB_SIZE     = 4,
    parameter int unsigned COUNT_WIDTH  = 5,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                                                         clk_in,
    input  logic                                                         rst_n_in,
    input  logic                                                         start_in,
    input  logic [$clog2(WIDTH)-1:0]                                     x_in,
    input  logic [$clog2(HEIGHT)-1:0]                                    y_in,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]                              x_read_addr,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]                              y_read_addr,
    input  logic [BIT_DEPTH-1:0]                                         x_grad_in,
    input  logic [BIT_DEPTH-1:0]                                         y_grad_in,
    output logic                                                         busy_out,
    output logic                                                         hist_valid_out,
    input  logic                                                         hist_ready_in,
    output logic [$clog2((PATCH_SIZE/SUB_SIZE)*(PATCH_SIZE/SUB_SIZE))-1:0] hist_idx_out,
    output logic [8*COUNT_WIDTH-1:0]                                     histogram_out,
    output logic                                                         done_out,
    output logic                                                         oob_out
);

    localparam int unsigned XW          = $clog2(WIDTH);
    localparam int unsigned YW          = $clog2(HEIGHT);
    localparam int unsigned AW          = $clog2(WIDTH*HEIGHT);
    localparam int unsigned PW          = $clog2(PATCH_SIZE);
    localparam int unsigned SUB_PER_ROW = PATCH_SIZE / SUB_SIZE;
    localparam int unsigned NUM_SUB     = SUB_PER_ROW * SUB_PER_ROW;
    localparam int unsigned IDX_W       = $clog2(NUM_SUB);
    localparam int unsigned NBINS       = 8;
    localparam int unsigned AXW         = BIT_DEPTH + 1;
    localparam int unsigned INC_W       = AXW + 1;
    localparam int unsigned SUM_W       = ((COUNT_WIDTH > INC_W) ? COUNT_WIDTH : INC_W) + 1;
    localparam int unsigned DW          = $clog2(READ_LATENCY + 1) + 1;
    localparam int unsigned CNT_MAX     = (1 << COUNT_WIDTH) - 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_SCAN  = 3'd2,
        S_DRAIN = 3'd3,
        S_EMIT  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [XW-1:0]      x_q;
    logic [YW-1:0]      y_q;
    logic               oob_c, scan_last_c, drain_last_c, last_xfer_c;
    logic               busy_d, done_d, oob_d;

    logic [PW-1:0]      pos_r, pos_c;
    logic               issue_v;
    logic [AW-1:0]      addr_q;
    logic               tag_v [1:READ_LATENCY];
    logic [PW-1:0]      tag_r [1:READ_LATENCY];
    logic [PW-1:0]      tag_c [1:READ_LATENCY];
    logic [DW-1:0]      drain_cnt;

    logic [AXW-1:0]     gx_ext, gy_ext, ax_c, ay_c;
    logic               gx_neg, gy_neg, gx_zero, gy_zero, gx_pos, gy_pos;
    logic [2:0]         bin_c;
    logic [IDX_W-1:0]   sub_c;
    logic               bin_v;
    logic [2:0]         bin_q;
    logic [IDX_W-1:0]   bin_sub;
`ifdef PATCH_HIST_MAGNITUDE_EN
    logic [INC_W-1:0]   mag_q;
`endif
    logic [INC_W-1:0]   inc_c;
    logic [SUM_W-1:0]   sum_c;
    logic [COUNT_WIDTH-1:0] cnt [NUM_SUB][NBINS];
    logic [IDX_W:0]     emit_ptr;

    assign x_read_addr = addr_q;
    assign y_read_addr = addr_q;

    assign oob_c        = (32'(x_q) + PATCH_SIZE > WIDTH) || (32'(y_q) + PATCH_SIZE > HEIGHT);
    assign scan_last_c  = (state_q == S_SCAN) && (pos_r == PW'(PATCH_SIZE - 1)) &&
                          (pos_c == PW'(PATCH_SIZE - 1));
    assign drain_last_c = (state_q == S_DRAIN) && (drain_cnt == DW'(READ_LATENCY));
    assign last_xfer_c  = (state_q == S_EMIT) && hist_valid_out && hist_ready_in &&
                          (hist_idx_out == IDX_W'(NUM_SUB - 1));

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_in)     state_d = S_CHECK;
            S_CHECK: state_d = oob_c ? S_IDLE : S_SCAN;
            S_SCAN:  if (scan_last_c)  state_d = S_DRAIN;
            S_DRAIN: if (drain_last_c) state_d = S_EMIT;
            S_EMIT:  if (last_xfer_c)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode, registered below
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        oob_d  = 1'b0;
        busy_d = (state_d != S_IDLE);
        if (state_q == S_CHECK && oob_c) begin
            done_d = 1'b1;
            oob_d  = 1'b1;
        end
        if (last_xfer_c) done_d = 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_out <= 1'b0;
            done_out <= 1'b0;
            oob_out  <= 1'b0;
        end else begin
            busy_out <= busy_d;
            done_out <= done_d;
            oob_out  <= oob_d;
        end
    end

    // Patch origin capture and raster address generation
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            x_q     <= '0;
            y_q     <= '0;
            pos_r   <= '0;
            pos_c   <= '0;
            issue_v <= 1'b0;
            addr_q  <= '0;
        end else begin
            if (state_q == S_IDLE && start_in) begin
                x_q <= x_in;
                y_q <= y_in;
            end
            if (state_q == S_CHECK && !oob_c) begin
                addr_q  <= AW'(32'(y_q) * WIDTH + 32'(x_q));
                pos_r   <= '0;
                pos_c   <= '0;
                issue_v <= 1'b1;
            end else if (state_q == S_SCAN && !scan_last_c) begin
                issue_v <= 1'b1;
                if (pos_c == PW'(PATCH_SIZE - 1)) begin
                    pos_c  <= '0;
                    pos_r  <= pos_r + PW'(1);
                    addr_q <= addr_q + AW'(WIDTH - PATCH_SIZE + 1);
                end else begin
                    pos_c  <= pos_c + PW'(1);
                    addr_q <= addr_q + AW'(1);
                end
            end else begin
                issue_v <= 1'b0;
            end
        end
    end

    // Tag pipeline tracking each address until its gradient returns
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 1; i <= READ_LATENCY; i++) begin
                tag_v[i] <= 1'b0;
                tag_r[i] <= '0;
                tag_c[i] <= '0;
            end
        end else begin
            tag_v[1] <= issue_v;
            tag_r[1] <= pos_r;
            tag_c[1] <= pos_c;
            for (int i = 2; i <= READ_LATENCY; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_r[i] <= tag_r[i-1];
                tag_c[i] <= tag_c[i-1];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)                drain_cnt <= '0;
        else if (state_q == S_DRAIN)  drain_cnt <= drain_cnt + DW'(1);
        else                          drain_cnt <= '0;
    end

    // Octant binning; magnitudes carry one extra bit so the most negative gradient is exact
    always_comb begin
        gx_ext  = {x_grad_in[BIT_DEPTH-1], x_grad_in};
        gy_ext  = {y_grad_in[BIT_DEPTH-1], y_grad_in};
        gx_neg  = x_grad_in[BIT_DEPTH-1];
        gy_neg  = y_grad_in[BIT_DEPTH-1];
        gx_zero = (x_grad_in == '0);
        gy_zero = (y_grad_in == '0);
        gx_pos  = !gx_neg && !gx_zero;
        gy_pos  = !gy_neg && !gy_zero;
        ax_c    = gx_neg ? (~gx_ext + AXW'(1)) : gx_ext;
        ay_c    = gy_neg ? (~gy_ext + AXW'(1)) : gy_ext;
        bin_c   = 3'd0;
        if (gx_zero && gy_zero)        bin_c = 3'd0;
        else if (gx_pos && !gy_neg)    bin_c = (ay_c < ax_c) ? 3'd0 : 3'd1;
        else if (!gx_pos && gy_pos)    bin_c = (ax_c < ay_c) ? 3'd2 : 3'd3;
        else if (gx_neg && !gy_pos)    bin_c = (ay_c < ax_c) ? 3'd4 : 3'd5;
        else                           bin_c = (ax_c < ay_c) ? 3'd6 : 3'd7;
        sub_c = IDX_W'((32'(tag_r[READ_LATENCY]) / SUB_SIZE) * SUB_PER_ROW +
                       32'(tag_c[READ_LATENCY]) / SUB_SIZE);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bin_v   <= 1'b0;
            bin_q   <= '0;
            bin_sub <= '0;
`ifdef PATCH_HIST_MAGNITUDE_EN
            mag_q   <= '0;
`endif
        end else begin
            bin_v   <= tag_v[READ_LATENCY];
            bin_q   <= bin_c;
            bin_sub <= sub_c;
`ifdef PATCH_HIST_MAGNITUDE_EN
            mag_q   <= {1'b0, ax_c} + {1'b0, ay_c};
`endif
        end
    end

`ifdef PATCH_HIST_MAGNITUDE_EN
    assign inc_c = mag_q;
`else
    assign inc_c = INC_W'(1);
`endif
    assign sum_c = SUM_W'(cnt[bin_sub][bin_q]) + SUM_W'(inc_c);

    // Saturating per-subpatch bin counters
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int s = 0; s < NUM_SUB; s++)
                for (int k = 0; k < NBINS; k++)
                    cnt[s][k] <= '0;
        end else if (state_q == S_CHECK && !oob_c) begin
            for (int s = 0; s < NUM_SUB; s++)
                for (int k = 0; k < NBINS; k++)
                    cnt[s][k] <= '0;
        end else if (bin_v) begin
            cnt[bin_sub][bin_q] <= (sum_c > SUM_W'(CNT_MAX)) ? COUNT_WIDTH'(CNT_MAX)
                                                            : COUNT_WIDTH'(sum_c);
        end
    end

    // Histogram stream; payload only changes when the slot is empty or being accepted
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            emit_ptr       <= '0;
            hist_valid_out <= 1'b0;
            hist_idx_out   <= '0;
            histogram_out  <= '0;
        end else if (state_q != S_EMIT) begin
            emit_ptr       <= '0;
            hist_valid_out <= 1'b0;
        end else if (!hist_valid_out || hist_ready_in) begin
            if (emit_ptr < (IDX_W+1)'(NUM_SUB)) begin
                hist_valid_out <= 1'b1;
                hist_idx_out   <= IDX_W'(emit_ptr);
                for (int k = 0; k < NBINS; k++)
                    histogram_out[k*COUNT_WIDTH +: COUNT_WIDTH] <= cnt[IDX_W'(emit_ptr)][k];
                emit_ptr       <= emit_ptr + (IDX_W+1)'(1);
            end else begin
                hist_valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_patch_histogram_engine.sv
// Scoreboard bench for patch_histogram_engine: randomized gradient fields, an octant reference model
// based on quarter-turn rotation, and a separate monitor that checks every presented histogram.
module tb_patch_histogram_engine;

    localparam int W      = 64;
    localparam int H      = 64;
    localparam int BD     = 8;
    localparam int P      = 8;
    localparam int S      = 4;
    localparam int CW     = 4;
    localparam int L      = 2;
    localparam int NS     = (P / S) * (P / S);
    localparam int XW     = $clog2(W);
    localparam int YW     = $clog2(H);
    localparam int AW     = $clog2(W * H);
    localparam int IW     = $clog2(NS);
    localparam int HW     = 8 * CW;
    localparam int MAXC   = (1 << CW) - 1;
    localparam int BUDGET = 2000;

    logic          clk;
    logic          rst_n;
    logic          start_in;
    logic [XW-1:0] x_in;
    logic [YW-1:0] y_in;
    logic [AW-1:0] x_read_addr, y_read_addr;
    logic [BD-1:0] x_grad_in, y_grad_in;
    logic          busy_out, hist_valid_out, hist_ready_in, done_out, oob_out;
    logic [IW-1:0] hist_idx_out;
    logic [HW-1:0] histogram_out;

    patch_histogram_engine #(
        .WIDTH(W), .HEIGHT(H), .BIT_DEPTH(BD), .PATCH_SIZE(P), .SUB_SIZE(S),
        .COUNT_WIDTH(CW), .READ_LATENCY(L)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start_in), .x_in(x_in), .y_in(y_in),
        .x_read_addr(x_read_addr), .y_read_addr(y_read_addr),
        .x_grad_in(x_grad_in), .y_grad_in(y_grad_in), .busy_out(busy_out),
        .hist_valid_out(hist_valid_out), .hist_ready_in(hist_ready_in),
        .hist_idx_out(hist_idx_out), .histogram_out(histogram_out),
        .done_out(done_out), .oob_out(oob_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gradient memories with READ_LATENCY cycles of read delay
    logic [BD-1:0] gx_mem [W*H];
    logic [BD-1:0] gy_mem [W*H];
    logic [BD-1:0] rdx [L];
    logic [BD-1:0] rdy [L];
    always @(posedge clk) begin
        rdx[0] <= gx_mem[x_read_addr];
        rdy[0] <= gy_mem[y_read_addr];
        for (int i = 1; i < L; i++) begin
            rdx[i] <= rdx[i-1];
            rdy[i] <= rdy[i-1];
        end
    end
    assign x_grad_in = rdx[L-1];
    assign y_grad_in = rdy[L-1];

    int            checks = 0;
    int            errors = 0;
    int            exp_idx [$];
    logic [HW-1:0] exp_hist [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Quarter-turn the vector into x>0,y>=0; each turn is two octants, the diagonal goes to the upper one
    function automatic int ref_bin(input int gx, input int gy);
        int x, y, t, q;
        if (gx == 0 && gy == 0) return 0;
        x = gx; y = gy; q = 0;
        while (!(x > 0 && y >= 0)) begin
            t = x; x = y; y = -t; q++;
        end
        return 2 * q + ((y >= x) ? 1 : 0);
    endfunction

    task automatic push_expected(input int px, input int py);
        int h [NS][8];
        int gx, gy, a, b, s, inc;
        logic [HW-1:0] v;
        for (int i = 0; i < NS; i++)
            for (int k = 0; k < 8; k++) h[i][k] = 0;
        for (int r = 0; r < P; r++) begin
            for (int c = 0; c < P; c++) begin
                a  = (py + r) * W + px + c;
                gx = int'($signed(gx_mem[a]));
                gy = int'($signed(gy_mem[a]));
                b  = ref_bin(gx, gy);
`ifdef PATCH_HIST_MAGNITUDE_EN
                inc = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
`else
                inc = 1;
`endif
                s = (r / S) * (P / S) + c / S;
                h[s][b] = (h[s][b] + inc > MAXC) ? MAXC : h[s][b] + inc;
            end
        end
        for (int i = 0; i < NS; i++) begin
            v = '0;
            for (int k = 0; k < 8; k++) v[k*CW +: CW] = CW'(h[i][k]);
            exp_idx.push_back(i);
            exp_hist.push_back(v);
        end
    endtask

    task automatic fill_uniform(input int gx, input int gy);
        for (int i = 0; i < W * H; i++) begin
            gx_mem[i] = BD'(gx);
            gy_mem[i] = BD'(gy);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < W * H; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                gx_mem[i] = BD'($urandom_range(0, 4)) - BD'(2);
                gy_mem[i] = BD'($urandom_range(0, 4)) - BD'(2);
            end else begin
                gx_mem[i] = BD'($urandom);
                gy_mem[i] = BD'($urandom);
            end
        end
    endtask

    task automatic fill_split(input int px, input int py);
        fill_uniform(0, -7);
        for (int r = 0; r < S; r++)
            for (int c = 0; c < S; c++) begin
                gx_mem[(py + r) * W + px + c] = BD'(-3);
                gy_mem[(py + r) * W + px + c] = BD'(3);
            end
    endtask

    // Monitor: every presented histogram must match the head of the expected queue
    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (rst_n && hist_valid_out) begin
                if (exp_idx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_hist: idx=%0d hist=0x%0h presented with nothing expected",
                             hist_idx_out, histogram_out);
                end else begin
                    check("hist_idx", 64'(hist_idx_out), 64'(exp_idx[0]));
                    check("hist_bins", 64'(histogram_out), 64'(exp_hist[0]));
                    if (hist_ready_in) begin
                        void'(exp_idx.pop_front());
                        void'(exp_hist.pop_front());
                    end
                end
            end
        end
    endtask

    // rmode 0: ready high, 1: random ready, 2: 5-cycle stalls at idx 0 and 2
    task automatic run_patch(input int px, input int py, input int rmode);
        bit oob_exp, got, st0, st2;
        int lat, stall_cnt, exp_lat;
        oob_exp   = (px + P > W) || (py + P > H);
        got = 1'b0; st0 = 1'b0; st2 = 1'b0; lat = 0; stall_cnt = 0;
        exp_lat   = oob_exp ? 1 : P * P + L + NS + 3;
        if (!oob_exp) push_expected(px, py);
        @(posedge clk); #1;
        start_in      = 1'b1;
        x_in          = XW'(px);
        y_in          = YW'(py);
        hist_ready_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        check("busy_after_start", 64'(busy_out), 64'd1);
        for (int n = 1; n <= BUDGET && !got; n++) begin
            @(posedge clk); #1;
            if (done_out) begin
                got = 1'b1;
                lat = n;
            end
            start_in = (rmode == 0) && !oob_exp && (n == 10);
            x_in = '0;
            y_in = '0;
            if (rmode == 1) begin
                hist_ready_in = ($urandom_range(0, 2) != 0);
            end else if (rmode == 2) begin
                if (hist_valid_out && ((hist_idx_out == 0 && !st0) || (hist_idx_out == 2 && !st2))) begin
                    hist_ready_in = 1'b0;
                    stall_cnt++;
                    if (stall_cnt == 5) begin
                        if (hist_idx_out == 0) st0 = 1'b1;
                        else st2 = 1'b1;
                        stall_cnt = 0;
                    end
                end else begin
                    hist_ready_in = 1'b1;
                end
            end else begin
                hist_ready_in = 1'b1;
            end
        end
        start_in      = 1'b0;
        hist_ready_in = 1'b1;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done_out within %0d cycles for patch (%0d,%0d)", BUDGET, px, py);
            exp_idx.delete();
            exp_hist.delete();
        end else begin
            check("done_oob", 64'(oob_out), 64'(oob_exp));
            check("busy_at_done", 64'(busy_out), 64'd0);
            check("all_hist_delivered", 64'(exp_idx.size()), 64'd0);
            if (rmode == 0) check("done_latency", 64'(lat), 64'(exp_lat));
            @(posedge clk); #1;
            check("done_single_pulse", 64'(done_out), 64'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy_out), 64'd0);
        check({tag, "_valid"}, 64'(hist_valid_out), 64'd0);
        check({tag, "_done"}, 64'(done_out), 64'd0);
        check({tag, "_oob"}, 64'(oob_out), 64'd0);
        check({tag, "_addr"}, 64'(x_read_addr), 64'd0);
        check({tag, "_idx"}, 64'(hist_idx_out), 64'd0);
        check({tag, "_hist"}, 64'(histogram_out), 64'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        start_in      = 1'b0;
        hist_ready_in = 1'b1;
        x_in          = '0;
        y_in          = '0;
        fill_uniform(0, 0);
        fork
            monitor_loop();
        join_none
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        fill_uniform(5, 0);
        run_patch(8, 8, 0);

        fill_split(16, 24);
        run_patch(16, 24, 0);

        run_patch(60, 10, 0);
        run_patch(57, 0, 0);
        run_patch(0, 57, 1);

        fill_random();
        run_patch(56, 56, 0);

        fill_random();
        run_patch(20, 30, 2);

        for (int t = 0; t < 6; t++) begin
            fill_random();
            run_patch(int'($urandom_range(0, W - P)), int'($urandom_range(0, H - P)), 1);
        end

        fill_uniform(1, 1);
        run_patch(4, 40, 0);

        // Abort a scan with reset, then run a clean patch
        fill_random();
        @(posedge clk); #1;
        start_in = 1'b1;
        x_in     = XW'(8);
        y_in     = YW'(8);
        @(posedge clk); #1;
        start_in = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midscan_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fill_uniform(-128, 0);
        run_patch(0, 0, 0);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
